// File: rtl/sale_terminal_pkg.sv
// Shared constants, encodings and types for the sale terminal's basket logic.
// The basket geometry lives here so the store and its slot array agree on it.
package sale_terminal_pkg;

    localparam int MAX_ITEMS = 8;
    localparam int IDX_W     = 3;
    localparam int CNT_W     = 4;
    localparam logic [3:0] QTY_MAX = 4'd15;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_FULL = 2'b01;
    localparam logic [1:0] ERR_BAD  = 2'b10;
    localparam logic [1:0] ERR_BUSY = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEARCH = 3'd1,
        ST_MERGE  = 3'd2,
        ST_APPEND = 3'd3,
        ST_SHIFT  = 3'd4
    } basket_state_e;

    typedef struct packed {
        logic [3:0] id;
        logic [3:0] qty;
    } slot_t;

    // Merged quantities clip at QTY_MAX instead of wrapping.
    function automatic logic [3:0] merge_qty(input logic [3:0] old_qty, input logic [3:0] add_qty);
        logic [4:0] sum;
        sum = {1'b0, old_qty} + {1'b0, add_qty};
        return (sum > {1'b0, QTY_MAX}) ? QTY_MAX : sum[3:0];
    endfunction

endpackage

// File: rtl/basket_slot_array.sv
// Register file of basket slots: one write port, shift-down-by-one, clear,
// a combinational compare port and a registered, count-qualified read port.
module basket_slot_array
    import sale_terminal_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  slot_t            wr_slot,
    input  logic             shift_en,
    input  logic [IDX_W-1:0] shift_idx,
    input  logic [IDX_W-1:0] cmp_idx,
    input  logic [3:0]       cmp_id,
    output logic             cmp_match,
    output logic [3:0]       cmp_qty,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [CNT_W-1:0] count,
    output slot_t            rd_slot
);

    slot_t            slots [MAX_ITEMS];
    logic [IDX_W-1:0] shift_src;

    assign shift_src = shift_idx + IDX_W'(1);
    assign cmp_match = (slots[cmp_idx].id == cmp_id);
    assign cmp_qty   = slots[cmp_idx].qty;

    // NOTE: the slots are reset explicitly because an empty basket must read back as all-zero entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_ITEMS; i++) slots[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < MAX_ITEMS; i++) slots[i] <= '0;
        end else if (wr_en) begin
            slots[wr_idx] <= wr_slot;
        end else if (shift_en) begin
            slots[shift_idx] <= slots[shift_src];
        end
    end

    // Reads see the array before any write on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_slot <= '0;
        end else begin
            rd_slot <= (CNT_W'(rd_idx) < count) ? slots[rd_idx] : '0;
        end
    end

endmodule

// File: rtl/basket_entry_store.sv
// Ordered basket store: merges repeated products, appends new ones, removes
// by index with order preserved, and reports completion and rejected requests.
module basket_entry_store
    import sale_terminal_pkg::*;
(
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic             Add_En,
    input  logic [3:0]       ProductID_in,
    input  logic [3:0]       ProductQuantity_in,
    input  logic             Remove_En,
    input  logic [IDX_W-1:0] Remove_Index,
    input  logic             Clear_En,
    input  logic [IDX_W-1:0] Read_Index,
    output logic [3:0]       Read_ProductID,
    output logic [3:0]       Read_Quantity,
    output logic [3:0]       BasketProductNum,
    output logic             Full,
    output logic             Busy,
    output logic             Op_Done,
    output logic             Err,
    output logic [1:0]       Err_Code
);

    basket_state_e    state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [3:0]       id_q, id_d, qty_q, qty_d;
    logic             done_q, done_d, err_q, err_d;
    logic [1:0]       code_q, code_d;

    logic             clr, wr_en, shift_en, cmp_match, ptr_last;
    logic [IDX_W-1:0] wr_idx;
    slot_t            wr_slot, rd_slot;
    logic [3:0]       cmp_qty;

    basket_slot_array u_slots (
        .clk       (CLOCK_50),
        .rst_n     (RESET_N),
        .clr       (clr),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_slot   (wr_slot),
        .shift_en  (shift_en),
        .shift_idx (ptr_q),
        .cmp_idx   (ptr_q),
        .cmp_id    (id_q),
        .cmp_match (cmp_match),
        .cmp_qty   (cmp_qty),
        .rd_idx    (Read_Index),
        .count     (count_q),
        .rd_slot   (rd_slot)
    );

    assign ptr_last         = (CNT_W'(ptr_q) == count_q - CNT_W'(1));
    assign BasketProductNum = count_q;
    assign Full             = (count_q == CNT_W'(MAX_ITEMS));
    assign Busy             = (state_q != ST_IDLE);
    assign Op_Done          = done_q;
    assign Err              = err_q;
    assign Err_Code         = code_q;
    assign Read_ProductID   = rd_slot.id;
    assign Read_Quantity    = rd_slot.qty;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch can infer a latch.
        state_d  = state_q;
        ptr_d    = ptr_q;
        count_d  = count_q;
        id_d     = id_q;
        qty_d    = qty_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        code_d   = code_q;
        clr      = 1'b0;
        wr_en    = 1'b0;
        wr_idx   = ptr_q;
        wr_slot  = '0;
        shift_en = 1'b0;

        if (Clear_En) begin
            // Clear aborts whatever is in flight and swallows any same-cycle request silently.
            clr     = 1'b1;
            count_d = '0;
            ptr_d   = '0;
            state_d = ST_IDLE;
        end else begin
            if (state_q != ST_IDLE && (Add_En || Remove_En)) begin
                err_d  = 1'b1;
                code_d = ERR_BUSY;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (Remove_En) begin
                        if (CNT_W'(Remove_Index) >= count_q) begin
                            err_d  = 1'b1;
                            code_d = ERR_BAD;
                        end else begin
                            ptr_d   = Remove_Index;
                            state_d = ST_SHIFT;
                        end
                        if (Add_En && !err_d) begin
                            err_d  = 1'b1;
                            code_d = ERR_BUSY;
                        end
                    end else if (Add_En) begin
                        id_d  = ProductID_in;
                        qty_d = ProductQuantity_in;
                        ptr_d = '0;
                        if (ProductQuantity_in == 4'd0) begin
                            err_d  = 1'b1;
                            code_d = ERR_BAD;
                        end else if (count_q == '0) begin
                            state_d = ST_APPEND;
                        end else begin
                            state_d = ST_SEARCH;
                        end
                    end
                end
                ST_SEARCH: begin
                    if (cmp_match)     state_d = ST_MERGE;
                    else if (ptr_last) state_d = ST_APPEND;
                    else               ptr_d   = ptr_q + IDX_W'(1);
                end
                ST_MERGE: begin
                    wr_en   = 1'b1;
                    wr_slot = '{id: id_q, qty: merge_qty(cmp_qty, qty_q)};
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
                ST_APPEND: begin
                    if (Full) begin
                        err_d  = 1'b1;
                        code_d = ERR_FULL;
                    end else begin
                        wr_en   = 1'b1;
                        wr_idx  = count_q[IDX_W-1:0];
                        wr_slot = '{id: id_q, qty: qty_q};
                        count_d = count_q + CNT_W'(1);
                        done_d  = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                ST_SHIFT: begin
                    // The final step blanks the vacated tail slot instead of shifting.
                    if (ptr_last) begin
                        wr_en   = 1'b1;
                        count_d = count_q - CNT_W'(1);
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        shift_en = 1'b1;
                        ptr_d    = ptr_q + IDX_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            id_q    <= '0;
            qty_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            id_q    <= id_d;
            qty_q   <= qty_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

endmodule

// File: tb/tb_basket_entry_store.sv
// Self-checking bench for basket_entry_store: directed scenarios plus a random
// sequence, all scored against a queue-based model of the basket.
module tb_basket_entry_store;

    typedef struct packed {
        logic [3:0] id;
        logic [3:0] qty;
    } ent_t;

    typedef struct packed {
        logic [7:0] cycles;
        logic       done;
        logic       err;
        logic [1:0] code;
    } op_t;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N = 1'b0;
    logic       Add_En = 1'b0, Remove_En = 1'b0, Clear_En = 1'b0;
    logic [3:0] ProductID_in = '0, ProductQuantity_in = '0;
    logic [2:0] Remove_Index = '0, Read_Index = '0;
    logic [3:0] Read_ProductID, Read_Quantity, BasketProductNum;
    logic       Full, Busy, Op_Done, Err;
    logic [1:0] Err_Code;

    int vectors = 0;
    int miscompares = 0;

    ent_t       q[$];
    logic [1:0] m_code = 2'b00;
    ent_t       seen [8];

    basket_entry_store dut (
        .CLOCK_50           (CLOCK_50),
        .RESET_N            (RESET_N),
        .Add_En             (Add_En),
        .ProductID_in       (ProductID_in),
        .ProductQuantity_in (ProductQuantity_in),
        .Remove_En          (Remove_En),
        .Remove_Index       (Remove_Index),
        .Clear_En           (Clear_En),
        .Read_Index         (Read_Index),
        .Read_ProductID     (Read_ProductID),
        .Read_Quantity      (Read_Quantity),
        .BasketProductNum   (BasketProductNum),
        .Full               (Full),
        .Busy               (Busy),
        .Op_Done            (Op_Done),
        .Err                (Err),
        .Err_Code           (Err_Code)
    );

    initial forever #10 CLOCK_50 = ~CLOCK_50;

    // ---------------- reference model ----------------
    function automatic op_t model_add(input logic [3:0] id, input logic [3:0] qty);
        op_t e;
        int  k = -1;
        int  sum;
        e = '{cycles: 8'd0, done: 1'b0, err: 1'b0, code: m_code};
        foreach (q[i]) if (k < 0 && q[i].id == id) k = i;
        if (qty == 4'd0) begin
            e.err = 1'b1; e.code = 2'b10;
        end else if (k >= 0) begin
            e.cycles = 8'(k + 2);
            e.done = 1'b1;
            sum = int'(q[k].qty) + int'(qty);
            q[k].qty = (sum > 15) ? 4'd15 : 4'(sum);
        end else begin
            e.cycles = 8'(q.size() + 1);
            if (q.size() == 8) begin
                e.err = 1'b1; e.code = 2'b01;
            end else begin
                e.done = 1'b1;
                q.push_back('{id: id, qty: qty});
            end
        end
        m_code = e.code;
        return e;
    endfunction

    function automatic op_t model_remove(input int idx);
        op_t e;
        e = '{cycles: 8'd0, done: 1'b0, err: 1'b0, code: m_code};
        if (idx >= q.size()) begin
            e.err = 1'b1; e.code = 2'b10;
        end else begin
            e.cycles = 8'(q.size() - idx);
            e.done = 1'b1;
            q.delete(idx);
        end
        m_code = e.code;
        return e;
    endfunction

    function automatic ent_t model_slot(input int i);
        return (i < q.size()) ? q[i] : ent_t'(8'h00);
    endfunction

    function automatic string fmt_op(input op_t o);
        return $sformatf("cyc=%0d done=%b err=%b code=%b", o.cycles, o.done, o.err, o.code);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic run_op(input logic add, input logic rem, input logic [3:0] id,
                          input logic [3:0] qty, input logic [2:0] ridx, output op_t o);
        @(negedge CLOCK_50);
        Add_En = add; Remove_En = rem; ProductID_in = id; ProductQuantity_in = qty; Remove_Index = ridx;
        @(negedge CLOCK_50);
        Add_En = 1'b0; Remove_En = 1'b0;
        o = '{cycles: 8'd255, done: 1'b0, err: 1'b0, code: Err_Code};
        for (int c = 0; c < 40; c++) begin
            if (Op_Done || Err) begin
                o = '{cycles: 8'(c), done: Op_Done, err: Err, code: Err_Code};
                break;
            end
            @(negedge CLOCK_50);
        end
    endtask

    task automatic clear_basket();
        @(negedge CLOCK_50); Clear_En = 1'b1;
        @(negedge CLOCK_50); Clear_En = 1'b0;
        q.delete();
    endtask

    task automatic scan_slots();
        for (int i = 0; i < 8; i++) begin
            @(negedge CLOCK_50); Read_Index = 3'(i);
            @(negedge CLOCK_50); seen[i] = {Read_ProductID, Read_Quantity};
        end
    endtask

    task automatic add_checked(input string tag, input logic [3:0] id, input logic [3:0] qty);
        op_t o, e;
        run_op(1'b1, 1'b0, id, qty, 3'd0, o);
        e = model_add(id, qty);
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL %s add{%0d,%0d}: got %s, want %s", tag, id, qty, fmt_op(o), fmt_op(e));
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RESET_N = 1'b0;
        #25;
        vectors++;
        if ({Read_ProductID, Read_Quantity, BasketProductNum, Full, Busy, Op_Done, Err, Err_Code} !== 22'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got id=%h qty=%h num=%h full=%b busy=%b done=%b err=%b code=%b, want all 0",
                     Read_ProductID, Read_Quantity, BasketProductNum, Full, Busy, Op_Done, Err, Err_Code);
        end
        @(negedge CLOCK_50); RESET_N = 1'b1;
        scan_slots();
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (seen[i] !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_slot%0d: got %h, want 00", i, seen[i]);
            end
        end
    endtask

    task automatic test_single_add();
        clear_basket();
        add_checked("single", 4'd3, 4'd2);
        vectors++;
        if (BasketProductNum !== 4'd1) begin
            miscompares++;
            $display("FAIL single_count: got %0d, want 1", BasketProductNum);
        end
        scan_slots();
        vectors++;
        if (seen[0] !== 8'h32 || seen[1] !== 8'h00) begin
            miscompares++;
            $display("FAIL single_read: got %h/%h, want 32/00", seen[0], seen[1]);
        end
    endtask

    task automatic test_merge_saturate();
        clear_basket();
        add_checked("merge", 4'd3, 4'd2);
        add_checked("merge", 4'd3, 4'd4);
        for (int i = 0; i < 3; i++) add_checked("saturate", 4'd3, 4'd4);
        scan_slots();
        vectors++;
        if (BasketProductNum !== 4'd1 || seen[0] !== 8'h3F) begin
            miscompares++;
            $display("FAIL saturate_state: got num=%0d slot0=%h, want num=1 slot0=3f", BasketProductNum, seen[0]);
        end
    endtask

    task automatic test_full();
        clear_basket();
        for (int i = 0; i < 8; i++) add_checked("fill", 4'(i + 1), 4'(i % 4 + 1));
        add_checked("overflow", 4'd12, 4'd1);
        vectors++;
        if (Full !== 1'b1 || BasketProductNum !== 4'd8) begin
            miscompares++;
            $display("FAIL full_flags: got full=%b num=%0d, want full=1 num=8", Full, BasketProductNum);
        end
        scan_slots();
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (seen[i] !== model_slot(i)) begin
                miscompares++;
                $display("FAIL full_slot%0d: got %h, want %h", i, seen[i], model_slot(i));
            end
        end
    endtask

    task automatic test_remove();
        op_t o, e;
        clear_basket();
        for (int i = 1; i <= 4; i++) add_checked("rm_fill", 4'(i), 4'd1);
        run_op(1'b0, 1'b1, 4'd0, 4'd0, 3'd1, o);
        e = model_remove(1);
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL remove_mid: got %s, want %s", fmt_op(o), fmt_op(e));
        end
        scan_slots();
        vectors++;
        if ({seen[0].id, seen[1].id, seen[2].id, seen[3]} !== 20'h13400 || BasketProductNum !== 4'd3) begin
            miscompares++;
            $display("FAIL remove_order: got ids %0d,%0d,%0d slot3=%h num=%0d, want 1,3,4 slot3=00 num=3",
                     seen[0].id, seen[1].id, seen[2].id, seen[3], BasketProductNum);
        end
        run_op(1'b0, 1'b1, 4'd0, 4'd0, 3'd5, o);
        e = model_remove(5);
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL remove_bad_index: got %s, want %s", fmt_op(o), fmt_op(e));
        end
        run_op(1'b0, 1'b1, 4'd0, 4'd0, 3'd2, o);
        e = model_remove(2);
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL remove_last: got %s, want %s", fmt_op(o), fmt_op(e));
        end
    endtask

    task automatic test_busy_drop();
        op_t e;
        int  c;
        clear_basket();
        for (int i = 1; i <= 4; i++) add_checked("busy_fill", 4'(i), 4'd1);
        @(negedge CLOCK_50); Add_En = 1'b1; ProductID_in = 4'd9; ProductQuantity_in = 4'd2;
        @(negedge CLOCK_50); ProductID_in = 4'd5; ProductQuantity_in = 4'd1;
        vectors++;
        if (Busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_rise: got %b, want 1", Busy);
        end
        @(negedge CLOCK_50); Add_En = 1'b0;
        vectors++;
        if (Err !== 1'b1 || Err_Code !== 2'b11 || Op_Done !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_drop: got err=%b code=%b done=%b, want 1/11/0", Err, Err_Code, Op_Done);
        end
        c = 1;
        while (!Op_Done && c < 40) begin @(negedge CLOCK_50); c++; end
        m_code = 2'b11;
        e = model_add(4'd9, 4'd2);
        vectors++;
        if (c !== int'(e.cycles) || Err_Code !== e.code) begin
            miscompares++;
            $display("FAIL busy_original_add: got cyc=%0d code=%b, want cyc=%0d code=%b", c, Err_Code, e.cycles, e.code);
        end

        @(negedge CLOCK_50);
        Add_En = 1'b1; ProductID_in = 4'd7; ProductQuantity_in = 4'd1; Remove_En = 1'b1; Remove_Index = 3'd0;
        @(negedge CLOCK_50); Add_En = 1'b0; Remove_En = 1'b0;
        vectors++;
        if (Err !== 1'b1 || Err_Code !== 2'b11 || Busy !== 1'b1) begin
            miscompares++;
            $display("FAIL add_remove_same_cycle: got err=%b code=%b busy=%b, want 1/11/1", Err, Err_Code, Busy);
        end
        c = 0;
        while (!Op_Done && c < 40) begin @(negedge CLOCK_50); c++; end
        e = model_remove(0);
        vectors++;
        if (c !== int'(e.cycles)) begin
            miscompares++;
            $display("FAIL same_cycle_remove_latency: got %0d, want %0d", c, e.cycles);
        end
        scan_slots();
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (seen[i] !== model_slot(i)) begin
                miscompares++;
                $display("FAIL busy_slot%0d: got %h, want %h", i, seen[i], model_slot(i));
            end
        end
    endtask

    task automatic test_clear_mid_shift();
        logic saw_done = 1'b0, saw_err = 1'b0;
        @(negedge CLOCK_50); Remove_En = 1'b1; Remove_Index = 3'd0;
        @(negedge CLOCK_50); Remove_En = 1'b0;
        saw_done |= Op_Done; saw_err |= Err;
        @(negedge CLOCK_50); Clear_En = 1'b1; Remove_En = 1'b1;
        saw_done |= Op_Done; saw_err |= Err;
        @(negedge CLOCK_50); Clear_En = 1'b0; Remove_En = 1'b0;
        for (int i = 0; i < 6; i++) begin
            saw_done |= Op_Done; saw_err |= Err;
            @(negedge CLOCK_50);
        end
        q.delete();
        vectors++;
        if (saw_done !== 1'b0 || saw_err !== 1'b0 || BasketProductNum !== 4'd0 || Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_mid_shift: got done=%b err=%b num=%0d busy=%b, want 0/0/0/0",
                     saw_done, saw_err, BasketProductNum, Busy);
        end
        scan_slots();
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (seen[i] !== 8'h00) begin
                miscompares++;
                $display("FAIL cleared_slot%0d: got %h, want 00", i, seen[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        add_checked("rst_fill", 4'd6, 4'd3);
        add_checked("rst_fill", 4'd8, 4'd2);
        @(negedge CLOCK_50); Read_Index = 3'd0;
        @(negedge CLOCK_50); Add_En = 1'b1; ProductID_in = 4'd11; ProductQuantity_in = 4'd1;
        @(negedge CLOCK_50); Add_En = 1'b0;
        #3 RESET_N = 1'b0;
        #2;
        vectors++;
        if ({Read_ProductID, Read_Quantity, BasketProductNum, Full, Busy, Op_Done, Err, Err_Code} !== 22'd0) begin
            miscompares++;
            $display("FAIL async_reset: got id=%h qty=%h num=%h full=%b busy=%b done=%b err=%b code=%b, want all 0",
                     Read_ProductID, Read_Quantity, BasketProductNum, Full, Busy, Op_Done, Err, Err_Code);
        end
        @(negedge CLOCK_50); RESET_N = 1'b1;
        q.delete();
        m_code = 2'b00;
        add_checked("post_reset", 4'd2, 4'd4);
    endtask

    task automatic test_random();
        op_t o, e;
        int  kind, idx;
        logic [3:0] id, qty;
        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 19);
            if (kind < 11) begin
                id  = 4'($urandom_range(0, 9));
                qty = 4'($urandom_range(0, 4));
                add_checked("rand", id, qty);
            end else if (kind < 19) begin
                idx = $urandom_range(0, 7);
                run_op(1'b0, 1'b1, 4'd0, 4'd0, 3'(idx), o);
                e = model_remove(idx);
                vectors++;
                if (o !== e) begin
                    miscompares++;
                    $display("FAIL rand_remove[%0d]: got %s, want %s", idx, fmt_op(o), fmt_op(e));
                end
            end else begin
                @(negedge CLOCK_50); Clear_En = 1'b1; Add_En = 1'($urandom_range(0, 1));
                ProductQuantity_in = 4'd1;
                @(negedge CLOCK_50); Clear_En = 1'b0; Add_En = 1'b0;
                q.delete();
                vectors++;
                if (Err !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rand_clear_err: got %b, want 0", Err);
                end
            end
            vectors++;
            if ({Full, BasketProductNum, Err_Code} !== {q.size() == 8, 4'(q.size()), m_code}) begin
                miscompares++;
                $display("FAIL rand_count[%0d]: got full=%b num=%0d code=%b, want full=%b num=%0d code=%b",
                         n, Full, BasketProductNum, Err_Code, q.size() == 8, q.size(), m_code);
            end
            if (n % 20 == 19) begin
                scan_slots();
                for (int i = 0; i < 8; i++) begin
                    vectors++;
                    if (seen[i] !== model_slot(i)) begin
                        miscompares++;
                        $display("FAIL rand_slot%0d: got %h, want %h", i, seen[i], model_slot(i));
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_merge_saturate();
        test_full();
        test_remove();
        test_busy_drop();
        test_clear_mid_shift();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
